// File: rtl/cp0_param.sv
// cp0_param: parametrised coprocessor 0 for the pipelined MIPS CPU (sits beside M stage).
// Holds SR(12), Cause(13), EPC(14) and PRId(15), and arbitrates interrupts against
// exceptions. Req is raised combinationally so the pipe can flush in the same cycle.
//
// Optional feature: define CP0_TIMER_EN to build the Count(9)/Compare(11) timer.
// Without it, regs 9/11 read 0 and ignore writes, and Cause.TI reads 0.
//
// Parameters
//   NUM_HWINT  number of external interrupt lines (1..6), mapped to IP[10+i]
//   PRID       read-only value of PRId
// Ports
//   clk, reset   clock / asynchronous active-high reset
//   WE, CP0Addr, CP0In   mtc0 write port (CP0Addr also selects the mfc0 read)
//   CP0Out       mfc0 read data (combinational)
//   VPC, BDIn    PC of victim instruction and its delay-slot flag
//   ExcCodeIn    exception code from pipe, 0 = none
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret: clear SR.EXL
//   EPCOut       EPC for eret
//   Req          take exception/interrupt this cycle (combinational)
module cp0_param #(
  parameter int unsigned NUM_HWINT = 6,
  parameter logic [31:0] PRID      = 32'h0000_7A01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic [4:0]           CP0Addr,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req
);

  // Implemented hardware IM/IP bits; IM[9:8] (software) are always writable.
  localparam logic [5:0] HW_MASK  = 6'((32'd1 << NUM_HWINT) - 32'd1);
  localparam logic [7:0] IM_WMASK = {HW_MASK, 2'b11};

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // SR fields
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;
  logic [5:0]  hwip_q, hwip_d;
  logic [1:0]  swip_q, swip_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        ti;
  logic [5:0]  hw6;
  logic [7:0]  pend;
  logic        int_req;
  logic        exc_req;
  logic        wr;

  // Arbitration: live HWInt (not the registered IP copy) so Req has zero latency.
  always_comb begin
    hw6     = 6'(HWInt);
    pend    = {hw6, swip_q};
    pend[7] = hw6[5] | ti;
    int_req = (|(pend & im_q)) & ~exl_q & ie_q;
    exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    Req     = int_req | exc_req;
    // A taken exception/interrupt drops any concurrent mtc0.
    wr      = WE & ~Req;
  end

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    exc_d  = exc_q;
    hwip_d = hw6;
    swip_d = swip_q;
    epc_d  = epc_q;
    if (Req) begin
      // EXL stays set even if eret arrives in the same cycle.
      exl_d = 1'b1;
      bd_d  = BDIn;
      exc_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d = word_align(BDIn ? (VPC - 32'd4) : VPC);
    end else begin
      if (wr && CP0Addr == A_SR) begin
        im_d  = CP0In[15:8] & IM_WMASK;
        exl_d = CP0In[1];
        ie_d  = CP0In[0];
      end
      // eret wins over the EXL bit of a concurrent SR write.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
      if (wr && CP0Addr == A_CAUSE) begin
        swip_d = CP0In[9:8];
      end
      if (wr && CP0Addr == A_EPC) begin
        epc_d = word_align(CP0In);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q   <= 8'h00;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      exc_q  <= 5'd0;
      hwip_q <= 6'd0;
      swip_q <= 2'd0;
      epc_q  <= 32'h0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      exc_q  <= exc_d;
      hwip_q <= hwip_d;
      swip_q <= swip_d;
      epc_q  <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  assign ti = ti_q;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    // TI is sticky; only a Compare write clears it, and that write also masks
    // a match in the same cycle.
    ti_d      = ti_q | (count_q == compare_q);
    if (wr && CP0Addr == A_COUNT) begin
      count_d = CP0In;
    end
    if (wr && CP0Addr == A_COMPARE) begin
      compare_d = CP0In;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    case (CP0Addr)
      A_SR:      CP0Out = {16'h0, im_q, 6'h0, exl_q, ie_q};
      A_CAUSE:   CP0Out = {bd_q, ti, 14'h0, hwip_q, swip_q, 1'b0, exc_q, 2'b00};
      A_EPC:     CP0Out = epc_q;
      A_PRID:    CP0Out = PRID;
`ifdef CP0_TIMER_EN
      A_COUNT:   CP0Out = count_q;
      A_COMPARE: CP0Out = compare_q;
`endif
      default:   CP0Out = 32'h0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule
